sdrc_req_arbiter: RTL and testbench
===================================

// Module: sdrc_req_arbiter
// PURPOSE
//  Shares the single SDRAM-controller application request port among N_PORTS masters
//  (CPU, DMA, video, ...). Sits upstream of the bus-width converter. Round-robin grant
//  held for one whole transaction (request + full data phase); one transaction outstanding.
// PARAMETERS
//  N_PORTS  4   number of requesters (2..8)
//  APP_AW   30  application address width
//  APP_DW   32  application data width
//  APP_BW   4   application byte-enable width (APP_DW/8)
//  APP_RW   9   request length width, in APP_DW beats
// PORTS
//  clk           in   1               clock
//  reset_n       in   1               synchronous reset, active-low
//  p_req         in   N_PORTS         per-port request; held until p_ack
//  p_addr        in   N_PORTS*APP_AW  per-port address, port i at [i*APP_AW +: APP_AW]
//  p_len         in   N_PORTS*APP_RW  per-port burst length in beats
//  p_wr_n        in   N_PORTS         per-port direction: 0 write, 1 read
//  p_dma_last    in   N_PORTS         per-port last-of-DMA flag
//  p_wr_data     in   N_PORTS*APP_DW  per-port write data
//  p_wr_en_n     in   N_PORTS*APP_BW  per-port byte enables, active-low
//  p_ack         out  N_PORTS         one-cycle request accept, granted port only
//  p_wr_next     out  N_PORTS         write-beat consumed, granted port only
//  p_rd_valid    out  N_PORTS         read beat valid, granted port only
//  p_rd_data     out  APP_DW          read data, broadcast to all ports
//  m_sdr_req     out  1               downstream request
//  m_req_addr    out  APP_AW          downstream address
//  m_req_len     out  APP_RW          downstream length
//  m_req_wr_n    out  1               downstream direction
//  m_dma_last    out  1               downstream DMA-last
//  m_req_ack     in   1               downstream accept
//  m_wr_data     out  APP_DW          write data of granted port
//  m_wr_en_n     out  APP_BW          byte enables of granted port
//  m_wr_next     in   1               downstream consumed a write beat
//  m_rd_data     in   APP_DW          downstream read data
//  m_rd_valid    in   1               downstream read beat valid
//  gnt_id        out  clog2(N_PORTS)  current owner index (debug/perf)
//  busy          out  1               high in any state other than IDLE
// BEHAVIOUR
//  - FSM IDLE->REQ->{WDATA|RDATA}->IDLE. Reset: IDLE, rr pointer 0, gnt_id 0, beat count 0;
//    all outputs 0 except m_req_wr_n=1, m_wr_en_n all-ones. Reset mid-burst aborts silently.
//  - IDLE: if any p_req, pick winner = first requester at/after pointer (wrap); register
//    gnt_id; go REQ next cycle. m_sdr_req first asserted 1 cycle after p_req seen.
//  - REQ: m_sdr_req=1, m_req_* = granted port fields (combinational mux on gnt_id).
//    On m_req_ack: p_ack[gnt_id]=1 same cycle (combinational), load count=p_len,
//    pointer=gnt_id+1 mod N_PORTS; next state WDATA (wr_n=0) or RDATA (wr_n=1).
//    p_len==0: no data phase, go IDLE.
//  - WDATA: m_wr_data/m_wr_en_n muxed from owner; p_wr_next[gnt_id]=m_wr_next;
//    count decrements per m_wr_next; on count==1 && m_wr_next -> IDLE.
//  - RDATA: p_rd_valid[gnt_id]=m_rd_valid; p_rd_data=m_rd_data; count decrements per
//    m_rd_valid; on last beat -> IDLE. Stray m_wr_next/m_rd_valid in wrong state: ignored.
//  - Back-to-back: IDLE lasts exactly 1 cycle between transactions when requests pending.
//  - Owner dropping p_req during REQ is illegal (protocol assertion); request stays.
//  - Non-owner ports: p_ack/p_wr_next/p_rd_valid held 0 at all times.
// CONFIGURATION
//  SDRC_ARB_PRIO0_EN defined: port 0 wins in IDLE whenever it requests (strict priority),
//    rr pointer used only among ports 1..N-1; pointer not advanced on port-0 grants.
//  Undefined: pure round-robin over all ports.
// STRUCTURE
//  - sdrc_define.v: FSM state localparams (ARB_IDLE/ARB_REQ/ARB_WDATA/ARB_RDATA).
//  - Sub-module sdrc_rr_pick: combinational rotate-priority encoder (req vector, pointer
//    -> winner index, valid). FSM, counter, muxes live in sdrc_req_arbiter.
// TESTING
//  - Single port 2 write, len=4: p_ack[2] once, 4 p_wr_next[2] pulses, busy low after 4th.
//  - All 4 ports request reads len=1 continuously: grant order 0,1,2,3,0; no port starved.
//  - Port1 read len=8 in progress, port0 requests: port0 not acked until port1's 8th beat.
//  - len=0 write on port3: ack, FSM IDLE next cycle, no wr_next forwarded.
//  - reset_n low during WDATA beat 2 of 4: next cycle IDLE, m_sdr_req=0, pointer=0.
//  - SDRC_ARB_PRIO0_EN, ports 0 and 2 pending each slot: port0 wins every arbitration.

Source files
------------

// File: rtl/sdrc_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdrc_req_arbiter_pkg
//  Description : Shared types for the SDRAM-controller request arbiter.
//                Holds the FSM state encoding and the round-robin pointer
//                advance helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdrc_req_arbiter_pkg;

    // Width of the arbiter state register
    localparam int ARB_STATE_W = 2;

    // Arbiter FSM states
    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_REQ   = 2'd1,
        ARB_WDATA = 2'd2,
        ARB_RDATA = 2'd3
    } arb_state_e;

    // Next round-robin start position after index idx, wrapping at n
    function automatic int rr_advance(input int idx, input int n);
        rr_advance = (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdrc_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sdrc_rr_pick
//  Description : Combinational rotate-priority encoder. Returns the first
//                asserted request at or after ptr_i, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdrc_rr_pick #(
    parameter int N_PORTS = 4,
    parameter int GW      = 2
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [GW-1:0]      ptr_i,
    output logic [GW-1:0]      idx_o,
    output logic               valid_o
);

    logic [GW-1:0] w_cand;

    // Scan from the farthest offset down to zero so the nearest requester wins
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        w_cand  = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            w_cand = GW'((32'(ptr_i) + k) % N_PORTS);
            if (req_i[w_cand]) begin
                idx_o   = w_cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdrc_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdrc_req_arbiter
//  Description : Shares the single SDRAM-controller application request port
//                among N_PORTS masters. Round-robin grant, held for a whole
//                transaction (request plus full data phase), one transaction
//                outstanding at a time.
//  Options     : SDRC_ARB_PRIO0_EN - port 0 has strict priority; round-robin
//                applies among ports 1..N_PORTS-1 only.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdrc_req_arbiter
    import sdrc_req_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int APP_AW  = 30,
    parameter int APP_DW  = 32,
    parameter int APP_BW  = 4,
    parameter int APP_RW  = 9
) (
    input  logic                          clk,
    input  logic                          reset_n,
    // Requester side
    input  logic [N_PORTS-1:0]            p_req,
    input  logic [N_PORTS*APP_AW-1:0]     p_addr,
    input  logic [N_PORTS*APP_RW-1:0]     p_len,
    input  logic [N_PORTS-1:0]            p_wr_n,
    input  logic [N_PORTS-1:0]            p_dma_last,
    input  logic [N_PORTS*APP_DW-1:0]     p_wr_data,
    input  logic [N_PORTS*APP_BW-1:0]     p_wr_en_n,
    output logic [N_PORTS-1:0]            p_ack,
    output logic [N_PORTS-1:0]            p_wr_next,
    output logic [N_PORTS-1:0]            p_rd_valid,
    output logic [APP_DW-1:0]             p_rd_data,
    // Controller side
    output logic                          m_sdr_req,
    output logic [APP_AW-1:0]             m_req_addr,
    output logic [APP_RW-1:0]             m_req_len,
    output logic                          m_req_wr_n,
    output logic                          m_dma_last,
    input  logic                          m_req_ack,
    output logic [APP_DW-1:0]             m_wr_data,
    output logic [APP_BW-1:0]             m_wr_en_n,
    input  logic                          m_wr_next,
    input  logic [APP_DW-1:0]             m_rd_data,
    input  logic                          m_rd_valid,
    // Status
    output logic [$clog2(N_PORTS)-1:0]    gnt_id,
    output logic                          busy
);

    localparam int GW = $clog2(N_PORTS);

    arb_state_e        state_q;
    logic [GW-1:0]     gnt_id_q;
    logic [GW-1:0]     ptr_q;
    logic [GW-1:0]     ptr_d;
    logic [APP_RW-1:0] cnt_q;

    logic [N_PORTS-1:0] w_rr_req;
    logic [GW-1:0]      w_rr_idx;
    logic               w_rr_vld;
    logic [GW-1:0]      w_win_idx;
    logic               w_win_vld;
    logic               w_adv_ptr;

    logic [APP_AW-1:0]  w_sel_addr;
    logic [APP_RW-1:0]  w_sel_len;
    logic               w_sel_wr_n;
    logic               w_sel_dma;
    logic [APP_DW-1:0]  w_sel_wdata;
    logic [APP_BW-1:0]  w_sel_be_n;
    logic [N_PORTS-1:0] w_owner_oh;
    logic               w_in_req;
    logic               w_in_wdata;
    logic               w_in_rdata;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    sdrc_rr_pick #(
        .N_PORTS (N_PORTS),
        .GW      (GW)
    ) u_rr_pick (
        .req_i   (w_rr_req),
        .ptr_i   (ptr_q),
        .idx_o   (w_rr_idx),
        .valid_o (w_rr_vld)
    );

`ifdef SDRC_ARB_PRIO0_EN
    // Port 0 pre-empts the rotation; the pointer only rotates over ports 1..N-1
    assign w_rr_req  = {p_req[N_PORTS-1:1], 1'b0};
    assign w_win_vld = p_req[0] | w_rr_vld;
    assign w_win_idx = p_req[0] ? '0 : w_rr_idx;
    assign w_adv_ptr = (gnt_id_q != '0);
`else
    assign w_rr_req  = p_req;
    assign w_win_vld = w_rr_vld;
    assign w_win_idx = w_rr_idx;
    assign w_adv_ptr = 1'b1;
`endif

    // Pointer moves to the port just after the one being accepted
    assign ptr_d = GW'(rr_advance(32'(gnt_id_q), N_PORTS));

    // ------------------------------------------------------------------
    // Owner field muxes
    // ------------------------------------------------------------------
    assign w_sel_addr  = p_addr   [32'(gnt_id_q)*APP_AW +: APP_AW];
    assign w_sel_len   = p_len    [32'(gnt_id_q)*APP_RW +: APP_RW];
    assign w_sel_wdata = p_wr_data[32'(gnt_id_q)*APP_DW +: APP_DW];
    assign w_sel_be_n  = p_wr_en_n[32'(gnt_id_q)*APP_BW +: APP_BW];
    assign w_sel_wr_n  = p_wr_n[gnt_id_q];
    assign w_sel_dma   = p_dma_last[gnt_id_q];
    assign w_owner_oh  = N_PORTS'(1) << gnt_id_q;

    assign w_in_req   = (state_q == ARB_REQ);
    assign w_in_wdata = (state_q == ARB_WDATA);
    assign w_in_rdata = (state_q == ARB_RDATA);

    // ------------------------------------------------------------------
    // Arbiter FSM: grant, request hand-off and beat counting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (w_win_vld) begin
                        gnt_id_q <= w_win_idx;
                        state_q  <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (m_req_ack) begin
                        cnt_q <= w_sel_len;
                        if (w_adv_ptr) begin
                            ptr_q <= ptr_d;
                        end
                        if (w_sel_len == '0) begin
                            state_q <= ARB_IDLE;
                        end else if (w_sel_wr_n) begin
                            state_q <= ARB_RDATA;
                        end else begin
                            state_q <= ARB_WDATA;
                        end
                    end
                end
                ARB_WDATA: begin
                    if (m_wr_next) begin
                        cnt_q <= cnt_q - APP_RW'(1);
                        if (cnt_q == APP_RW'(1)) begin
                            state_q <= ARB_IDLE;
                        end
                    end
                end
                ARB_RDATA: begin
                    if (m_rd_valid) begin
                        cnt_q <= cnt_q - APP_RW'(1);
                        if (cnt_q == APP_RW'(1)) begin
                            state_q <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: request fields are only presented while in REQ so the
    // idle values (wr_n=1, byte enables off) hold everywhere else.
    // ------------------------------------------------------------------
    assign m_sdr_req  = w_in_req;
    assign m_req_addr = w_in_req ? w_sel_addr : '0;
    assign m_req_len  = w_in_req ? w_sel_len  : '0;
    assign m_req_wr_n = w_in_req ? w_sel_wr_n : 1'b1;
    assign m_dma_last = w_in_req ? w_sel_dma  : 1'b0;

    assign m_wr_data  = w_in_wdata ? w_sel_wdata : '0;
    assign m_wr_en_n  = w_in_wdata ? w_sel_be_n  : '1;

    assign p_ack      = (w_in_req   && m_req_ack)  ? w_owner_oh : '0;
    assign p_wr_next  = (w_in_wdata && m_wr_next)  ? w_owner_oh : '0;
    assign p_rd_valid = (w_in_rdata && m_rd_valid) ? w_owner_oh : '0;
    assign p_rd_data  = w_in_rdata ? m_rd_data : '0;

    assign gnt_id = gnt_id_q;
    assign busy   = (state_q != ARB_IDLE);

    // Owner must keep its request asserted until it is accepted
    a_owner_holds_req: assert property (
        @(posedge clk) disable iff (!reset_n)
        (state_q == ARB_REQ) |-> p_req[gnt_id_q]
    );

endmodule
`default_nettype wire

// File: tb/tb_sdrc_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sdrc_req_arbiter
//  Description : Directed self-checking bench for sdrc_req_arbiter. Expected
//                grants are queued when requests are posted and compared when
//                the arbiter presents the downstream request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdrc_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int RW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [N-1:0]      p_req;
    logic [N*AW-1:0]   p_addr;
    logic [N*RW-1:0]   p_len;
    logic [N-1:0]      p_wr_n;
    logic [N-1:0]      p_dma_last;
    logic [N*DW-1:0]   p_wr_data;
    logic [N*BW-1:0]   p_wr_en_n;
    logic [N-1:0]      p_ack;
    logic [N-1:0]      p_wr_next;
    logic [N-1:0]      p_rd_valid;
    logic [DW-1:0]     p_rd_data;
    logic              m_sdr_req;
    logic [AW-1:0]     m_req_addr;
    logic [RW-1:0]     m_req_len;
    logic              m_req_wr_n;
    logic              m_dma_last;
    logic              m_req_ack;
    logic [DW-1:0]     m_wr_data;
    logic [BW-1:0]     m_wr_en_n;
    logic              m_wr_next;
    logic [DW-1:0]     m_rd_data;
    logic              m_rd_valid;
    logic [1:0]        gnt_id;
    logic              busy;

    sdrc_req_arbiter #(
        .N_PORTS (N), .APP_AW (AW), .APP_DW (DW), .APP_BW (BW), .APP_RW (RW)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .p_req (p_req), .p_addr (p_addr), .p_len (p_len), .p_wr_n (p_wr_n),
        .p_dma_last (p_dma_last), .p_wr_data (p_wr_data), .p_wr_en_n (p_wr_en_n),
        .p_ack (p_ack), .p_wr_next (p_wr_next), .p_rd_valid (p_rd_valid),
        .p_rd_data (p_rd_data),
        .m_sdr_req (m_sdr_req), .m_req_addr (m_req_addr), .m_req_len (m_req_len),
        .m_req_wr_n (m_req_wr_n), .m_dma_last (m_dma_last), .m_req_ack (m_req_ack),
        .m_wr_data (m_wr_data), .m_wr_en_n (m_wr_en_n), .m_wr_next (m_wr_next),
        .m_rd_data (m_rd_data), .m_rd_valid (m_rd_valid),
        .gnt_id (gnt_id), .busy (busy)
    );

    typedef struct {
        int          port;
        logic [AW-1:0] addr;
        logic [RW-1:0] len;
        logic          wr_n;
        logic          dma;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] st_addr [N];
    logic [RW-1:0] st_len  [N];
    logic          st_wr_n [N];
    logic          st_dma  [N];
    logic [DW-1:0] st_wdata[N];
    logic [BW-1:0] st_be   [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int p);
        logic [N-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Drive a port's request fields and raise its request
    task automatic post(input int port, input logic [RW-1:0] len, input logic wr_n);
        st_addr[port]  = AW'($urandom);
        st_len[port]   = len;
        st_wr_n[port]  = wr_n;
        st_dma[port]   = ((port % 2) == 1);
        st_wdata[port] = $urandom;
        st_be[port]    = BW'($urandom);
        p_addr[port*AW +: AW]    = st_addr[port];
        p_len[port*RW +: RW]     = len;
        p_wr_n[port]             = wr_n;
        p_dma_last[port]         = st_dma[port];
        p_wr_data[port*DW +: DW] = st_wdata[port];
        p_wr_en_n[port*BW +: BW] = st_be[port];
        p_req[port]              = 1'b1;
    endtask

    task automatic expect_grant(input int port);
        sb.push_back('{port, st_addr[port], st_len[port], st_wr_n[port], st_dma[port]});
    endtask

    // Wait for the downstream request, compare against the scoreboard, accept it
    task automatic do_req(input int ack_delay, output int port);
        int   waited;
        exp_t e;
        waited = 0;
        while (m_sdr_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_latency", 64'(waited), 64'd1);
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty observed=0 expected=1");
            $fatal(1);
        end
        e    = sb.pop_front();
        port = e.port;
        #1;
        chk("gnt_id",     64'(gnt_id),     64'(e.port));
        chk("m_req_addr", 64'(m_req_addr), 64'(e.addr));
        chk("m_req_len",  64'(m_req_len),  64'(e.len));
        chk("m_req_wr_n", 64'(m_req_wr_n), 64'(e.wr_n));
        chk("m_dma_last", 64'(m_dma_last), 64'(e.dma));
        for (int i = 0; i < ack_delay; i++) begin
            chk("p_ack_before_accept", 64'(p_ack), 64'd0);
            @(posedge clk); @(negedge clk); #1;
            chk("req_held", 64'(m_sdr_req), 64'd1);
        end
        m_req_ack = 1'b1;
        #1;
        chk("p_ack", 64'(p_ack), 64'(oh(e.port)));
        @(posedge clk); @(negedge clk);
        m_req_ack = 1'b0;
        #1;
        chk("p_ack_clear", 64'(p_ack), 64'd0);
        chk("busy_after_ack", 64'(busy), 64'(e.len != '0));
    endtask

    // Run the data phase; abort_at >= 0 pulls reset on that beat
    task automatic do_data(input int port, input int len, input logic wr_n, input int abort_at);
        logic [DW-1:0] rd;
        for (int b = 0; b < len; b++) begin
            if (b == 1) begin
                if (wr_n) m_wr_next = 1'b1; else m_rd_valid = 1'b1;
                #1;
                chk("stray_wr_next",  64'(p_wr_next),  64'd0);
                chk("stray_rd_valid", 64'(p_rd_valid), 64'd0);
                @(posedge clk); @(negedge clk);
                m_wr_next  = 1'b0;
                m_rd_valid = 1'b0;
            end
            rd = $urandom;
            if (wr_n) begin
                m_rd_valid = 1'b1;
                m_rd_data  = rd;
            end else begin
                m_wr_next = 1'b1;
            end
            if (b == abort_at) reset_n = 1'b0;
            #1;
            if (wr_n) begin
                chk("p_rd_valid", 64'(p_rd_valid), 64'(oh(port)));
                chk("p_rd_data",  64'(p_rd_data),  64'(rd));
            end else begin
                chk("p_wr_next", 64'(p_wr_next), 64'(oh(port)));
                chk("m_wr_data", 64'(m_wr_data), 64'(st_wdata[port]));
                chk("m_wr_en_n", 64'(m_wr_en_n), 64'(st_be[port]));
            end
            chk("p_ack_in_data", 64'(p_ack), 64'd0);
            chk("req_in_data",   64'(m_sdr_req), 64'd0);
            @(posedge clk); @(negedge clk);
            m_wr_next  = 1'b0;
            m_rd_valid = 1'b0;
            #1;
            if (b == abort_at) begin
                chk("abort_busy",   64'(busy),      64'd0);
                chk("abort_req",    64'(m_sdr_req), 64'd0);
                chk("abort_gnt_id", 64'(gnt_id),    64'd0);
                chk("abort_wr_en",  64'(m_wr_en_n), 64'hF);
                return;
            end
            if (b != len - 1) chk("busy_mid_burst", 64'(busy), 64'd1);
        end
        chk("busy_end",     64'(busy),      64'd0);
        chk("req_idle_end", 64'(m_sdr_req), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int p;
        int order_b[5];
        int order_f[4];
        reset_n    = 1'b0;
        p_req      = '0;
        p_addr     = '0;
        p_len      = '0;
        p_wr_n     = '0;
        p_dma_last = '0;
        p_wr_data  = '0;
        p_wr_en_n  = '0;
        m_req_ack  = 1'b0;
        m_wr_next  = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        // Reset values
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_m_sdr_req",  64'(m_sdr_req),  64'd0);
        chk("rst_gnt_id",     64'(gnt_id),     64'd0);
        chk("rst_m_req_wr_n", 64'(m_req_wr_n), 64'd1);
        chk("rst_m_wr_en_n",  64'(m_wr_en_n),  64'hF);
        chk("rst_m_req_addr", 64'(m_req_addr), 64'd0);
        chk("rst_p_ack",      64'(p_ack),      64'd0);
        chk("rst_p_rd_data",  64'(p_rd_data),  64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single write on port 2, len 4, accept delayed one cycle
        post(2, 9'd4, 1'b0);
        expect_grant(2);
        do_req(1, p);
        p_req[2] = 1'b0;
        do_data(p, 4, 1'b0, -1);

        // Restart rotation from 0, then all four ports read continuously
        reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) post(i, 9'd1, 1'b1);
        order_b = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) expect_grant(order_b[i]);
        for (int i = 0; i < 5; i++) begin
            do_req(0, p);
            if (i == 4) p_req = '0;
            do_data(p, 1, 1'b1, -1);
        end

        // Port 1 long read; port 0 must wait for the whole burst
        post(1, 9'd8, 1'b1);
        expect_grant(1);
        do_req(0, p);
        p_req[1] = 1'b0;
        post(0, 9'd2, 1'b1);
        do_data(p, 8, 1'b1, -1);
        expect_grant(0);
        do_req(0, p);
        p_req[0] = 1'b0;
        do_data(p, 2, 1'b1, -1);

        // Zero-length write on port 3: no data phase
        post(3, 9'd0, 1'b0);
        expect_grant(3);
        do_req(0, p);
        p_req[3]  = 1'b0;
        m_wr_next = 1'b1;
        #1;
        chk("len0_wr_next", 64'(p_wr_next), 64'd0);
        @(posedge clk); @(negedge clk);
        m_wr_next = 1'b0;
        #1;
        chk("len0_busy", 64'(busy), 64'd0);

        // Reset during beat 2 of a 4-beat write; pointer must restart at 0
        post(2, 9'd4, 1'b0);
        expect_grant(2);
        do_req(0, p);
        p_req[2] = 1'b0;
        do_data(p, 4, 1'b0, 1);
        post(3, 9'd1, 1'b1);
        post(2, 9'd1, 1'b0);
        reset_n = 1'b1;
        expect_grant(2);
        expect_grant(3);
        do_req(0, p);
        p_req[2] = 1'b0;
        do_data(p, 1, 1'b0, -1);
        do_req(0, p);
        p_req[3] = 1'b0;
        do_data(p, 1, 1'b1, -1);

        // Ports 0 and 2 pending every slot
`ifdef SDRC_ARB_PRIO0_EN
        order_f = '{0, 0, 0, 0};
`else
        order_f = '{0, 2, 0, 2};
`endif
        post(0, 9'd1, 1'b1);
        post(2, 9'd1, 1'b1);
        for (int i = 0; i < 4; i++) expect_grant(order_f[i]);
        for (int i = 0; i < 4; i++) begin
            do_req(0, p);
            if (i == 3) p_req = '0;
            do_data(p, 1, 1'b1, -1);
        end

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
